// File: rtl/block_refill_unit_pkg.sv
// ============================================================================
// Module  : block_refill_unit_pkg
// Brief   : Shared cache types and helpers for the block refill engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package block_refill_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  // Clears the word-offset bits so any address inside a block maps to its base.
  function automatic logic [31:0] block_align(input logic [31:0] addr,
                                              input int unsigned blck_bits);
    return addr & ~((32'd1 << blck_bits) - 32'd1);
  endfunction

  function automatic int unsigned word_lsb(input int unsigned idx,
                                           input int unsigned word_size);
    return idx * word_size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_refill_unit_block_assembler.sv
// ============================================================================
// Module  : block_assembler
// Brief   : Word-addressed register array that builds the packed block image.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module block_assembler
  import block_refill_unit_pkg::*;
#(
  parameter int unsigned BLCK_ADDR    = 4,
  parameter int unsigned NUM_OF_WORDS = 16,
  parameter int unsigned WORD_SIZE    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [BLCK_ADDR-1:0]              wr_idx,
  input  logic [WORD_SIZE-1:0]              wr_data,
  output logic [WORD_SIZE*NUM_OF_WORDS-1:0] fill_data
);

  for (genvar gi = 0; gi < NUM_OF_WORDS; gi++) begin : g_word
    logic [WORD_SIZE-1:0] r_word;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_word <= '0;
      end else if (wr_en && (wr_idx == BLCK_ADDR'(gi))) begin
        r_word <= wr_data;
      end
    end

    assign fill_data[word_lsb(gi, WORD_SIZE) +: WORD_SIZE] = r_word;
  end

endmodule

`default_nettype wire

// File: rtl/block_refill_unit.sv
// ============================================================================
// Module  : block_refill_unit
// Brief   : Fetches one cache block word-by-word and presents it for bulk write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module block_refill_unit
  import block_refill_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned BLCK_ADDR    = 4,
  parameter int unsigned NUM_OF_WORDS = 16,
  parameter int unsigned WORD_SIZE    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              miss_req,
  input  logic [ADDR_WIDTH-1:0]             miss_addr,
  output logic                              miss_ack,
  output logic                              block_ready,
  output logic [ADDR_WIDTH-1:0]             fill_base,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  input  logic                              mem_rsp_valid,
  input  logic [WORD_SIZE-1:0]              mem_rsp_data,
  output logic [WORD_SIZE*NUM_OF_WORDS-1:0] fill_data,
  output logic                              new_block
);

  localparam logic [BLCK_ADDR:0] C_LAST = (BLCK_ADDR+1)'(NUM_OF_WORDS);
  localparam logic [BLCK_ADDR:0] C_ONE  = (BLCK_ADDR+1)'(1);

  fill_state_t           r_state;
  logic [BLCK_ADDR:0]    r_req_cnt;
  logic [BLCK_ADDR:0]    r_rsp_cnt;
  logic                  r_miss_ack;
  logic                  r_block_ready;
  logic [ADDR_WIDTH-1:0] r_fill_base;
  logic                  r_mem_req_valid;
  logic [ADDR_WIDTH-1:0] r_mem_req_addr;
  logic                  r_new_block;

  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_hs;
  logic                  w_rsp_take;
  logic                  w_rsp_last;
  logic [BLCK_ADDR:0]    w_req_cnt_nxt;
  logic [BLCK_ADDR:0]    w_rsp_cnt_nxt;

  assign w_base        = ADDR_WIDTH'(block_align(32'(miss_addr), BLCK_ADDR));
  assign w_hs          = r_mem_req_valid & mem_req_ready;
  assign w_req_cnt_nxt = r_req_cnt + C_ONE;
  assign w_rsp_cnt_nxt = r_rsp_cnt + C_ONE;
  // Responses are only meaningful while a fill is in flight and not yet full.
  assign w_rsp_take    = mem_rsp_valid && (r_rsp_cnt != C_LAST) &&
                         ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
  assign w_rsp_last    = w_rsp_take && (w_rsp_cnt_nxt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_req_cnt       <= '0;
      r_rsp_cnt       <= '0;
      r_miss_ack      <= 1'b0;
      r_block_ready   <= 1'b1;
      r_fill_base     <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_new_block     <= 1'b0;
    end else begin
      r_miss_ack  <= 1'b0;
      r_new_block <= 1'b0;
      if (w_rsp_take) begin
        r_rsp_cnt <= w_rsp_cnt_nxt;
      end

      case (r_state)
        ST_IDLE: begin
          if (miss_req) begin
            r_fill_base     <= w_base;
            r_mem_req_addr  <= w_base;
            r_req_cnt       <= '0;
            r_rsp_cnt       <= '0;
            r_miss_ack      <= 1'b1;
            r_mem_req_valid <= 1'b1;
            r_block_ready   <= 1'b0;
            r_state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_hs) begin
            r_req_cnt      <= w_req_cnt_nxt;
            r_mem_req_addr <= r_fill_base + ADDR_WIDTH'(w_req_cnt_nxt);
            if (w_req_cnt_nxt == C_LAST) begin
              r_mem_req_valid <= 1'b0;
              if (w_rsp_last) begin
                r_new_block <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_state <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_rsp_last) begin
            r_new_block <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_block_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  block_assembler #(
    .BLCK_ADDR   (BLCK_ADDR),
    .NUM_OF_WORDS(NUM_OF_WORDS),
    .WORD_SIZE   (WORD_SIZE)
  ) u_block_assembler (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_rsp_take),
    .wr_idx   (r_rsp_cnt[BLCK_ADDR-1:0]),
    .wr_data  (mem_rsp_data),
    .fill_data(fill_data)
  );

  assign miss_ack      = r_miss_ack;
  assign block_ready   = r_block_ready;
  assign fill_base     = r_fill_base;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign new_block     = r_new_block;

endmodule

`default_nettype wire

// File: tb/tb_block_refill_unit.sv
// ============================================================================
// Module  : tb_block_refill_unit
// Brief   : Scoreboard bench for block_refill_unit with a latency memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_refill_unit;

  localparam int AW = 16;
  localparam int BA = 4;
  localparam int NW = 16;
  localparam int WS = 16;
  localparam int BW = WS * NW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          miss_req = 1'b0;
  logic [AW-1:0] miss_addr = '0;
  logic          miss_ack;
  logic          block_ready;
  logic [AW-1:0] fill_base;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [WS-1:0] mem_rsp_data;
  logic [BW-1:0] fill_data;
  logic          new_block;

  block_refill_unit #(
    .ADDR_WIDTH  (AW),
    .BLCK_ADDR   (BA),
    .NUM_OF_WORDS(NW),
    .WORD_SIZE   (WS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .miss_ack     (miss_ack),
    .block_ready  (block_ready),
    .fill_base    (fill_base),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .fill_data    (fill_data),
    .new_block    (new_block)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int            due;
    logic [WS-1:0] data;
  } rsp_t;

  logic [AW-1:0] exp_addr_q[$];
  logic [BW-1:0] exp_blk_q[$];
  rsp_t          pend_q[$];

  int            lat = 1;
  bit            ready_toggle = 1'b0;
  bit            spur_tail = 1'b0;
  int            inj_req = 0;
  int            inj_done = 0;
  logic [WS-1:0] data_seed = '0;
  int            nb_cnt = 0;
  int            ack_cnt = 0;
  int            rsp_sent = 0;
  logic [BW-1:0] last_blk = '0;

  // Memory model and output monitor, active on the falling edge.
  initial begin
    bit            stalled;
    bit            spur_pend;
    logic [AW-1:0] stall_addr;
    rsp_t          r;
    stalled       = 1'b0;
    spur_pend     = 1'b0;
    stall_addr    = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_addr_q.delete();
        exp_blk_q.delete();
        pend_q.delete();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        rsp_sent      = 0;
        stalled       = 1'b0;
        spur_pend     = 1'b0;
        continue;
      end
      if (new_block) begin
        nb_cnt++;
        if (exp_blk_q.size() == 0) check("extra_new_block", BW'(1), BW'(0));
        else check("block_data", fill_data, exp_blk_q.pop_front());
      end
      if (miss_ack) begin
        ack_cnt++;
        rsp_sent = 0;
      end
      if (stalled) begin
        check("stall_valid", BW'(mem_req_valid), BW'(1));
        check("stall_addr", BW'(mem_req_addr), BW'(stall_addr));
      end
      mem_req_ready = ready_toggle ? ((cyc % 2) == 0) : 1'b1;
      stalled    = mem_req_valid && !mem_req_ready;
      stall_addr = mem_req_addr;
      if (mem_req_valid && mem_req_ready) begin
        if (exp_addr_q.size() == 0) check("extra_req", BW'(1), BW'(0));
        else check("req_addr", BW'(mem_req_addr), BW'(exp_addr_q.pop_front()));
        r.due  = cyc + lat;
        r.data = data_seed + WS'(mem_req_addr[BA-1:0]);
        pend_q.push_back(r);
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = r.data;
        rsp_sent++;
        if (rsp_sent == NW && spur_tail) spur_pend = 1'b1;
      end else if (spur_pend) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 16'hDEAD;
        spur_pend     = 1'b0;
      end else if (inj_req != inj_done) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 16'hDEAD;
        inj_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_fill(input logic [AW-1:0] addr, input logic [WS-1:0] seed);
    logic [AW-1:0] base;
    logic [BW-1:0] blk;
    base = {addr[AW-1:BA], BA'(0)};
    blk  = '0;
    data_seed = seed;
    for (int i = 0; i < NW; i++) begin
      exp_addr_q.push_back(base + AW'(i));
      blk[i*WS +: WS] = seed + WS'(i);
    end
    exp_blk_q.push_back(blk);
    last_blk  = blk;
    miss_addr = addr;
    miss_req  = 1'b1;
  endtask

  task automatic wait_new_block(input string tag, input int t0, input int exp_cyc);
    int n;
    n = 0;
    while (!new_block && n < 300) begin
      tick();
      n++;
    end
    if (!new_block) check({tag, "_timeout"}, BW'(0), BW'(1));
    else if (exp_cyc != 0) check({tag, "_nb_cycle"}, BW'(cyc - t0), BW'(exp_cyc));
  endtask

  task automatic run_fill(input string tag, input logic [AW-1:0] addr,
                          input logic [WS-1:0] seed, input int exp_cyc);
    int t0;
    start_fill(addr, seed);
    t0 = cyc;
    tick();
    miss_req = 1'b0;
    check({tag, "_ack"}, BW'(miss_ack), BW'(1));
    check({tag, "_base"}, BW'(fill_base), BW'({addr[AW-1:BA], BA'(0)}));
    wait_new_block(tag, t0, exp_cyc);
    check({tag, "_reqs_left"}, BW'(exp_addr_q.size()), BW'(0));
    tick();
    check({tag, "_ready_after"}, BW'(block_ready), BW'(1));
    check({tag, "_valid_after"}, BW'(mem_req_valid), BW'(0));
  endtask

  initial begin
    int nb0;
    int ack0;
    int n;
    int t0;

    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", BW'(block_ready), BW'(1));
    check("rst_ack", BW'(miss_ack), BW'(0));
    check("rst_valid", BW'(mem_req_valid), BW'(0));
    check("rst_nb", BW'(new_block), BW'(0));
    check("rst_addr", BW'(mem_req_addr), BW'(0));
    check("rst_base", BW'(fill_base), BW'(0));
    check("rst_data", fill_data, BW'(0));
    rst = 1'b0;
    tick();

    run_fill("basic", 16'h1234, 16'hA000, 18);

    ready_toggle = 1'b1;
    run_fill("bp", 16'h3456, 16'hB000, 0);
    ready_toggle = 1'b0;

    // Held request: one ack per fill, second fill begins right after new_block.
    ack0 = ack_cnt;
    start_fill(16'h1111, 16'hC000);
    t0 = cyc;
    tick();
    check("busy_ack1", BW'(miss_ack), BW'(1));
    wait_new_block("busy1", t0, 18);
    check("busy_one_ack", BW'(ack_cnt - ack0), BW'(1));
    start_fill(16'h2000, 16'hD000);
    tick();
    check("busy_idle_ready", BW'(block_ready), BW'(1));
    check("busy_idle_noack", BW'(miss_ack), BW'(0));
    tick();
    miss_req = 1'b0;
    check("busy_ack2", BW'(miss_ack), BW'(1));
    check("busy_base2", BW'(fill_base), BW'(16'h2000));
    wait_new_block("busy2", 0, 0);
    tick();
    check("busy_two_acks", BW'(ack_cnt - ack0), BW'(2));

    // Reset after five responses have been captured.
    nb0 = nb_cnt;
    start_fill(16'h0500, 16'hE000);
    tick();
    miss_req = 1'b0;
    tick();
    n = 0;
    while (rsp_sent < 5 && n < 100) begin
      tick();
      n++;
    end
    check("mid_rsp_seen", BW'(rsp_sent >= 5), BW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_ready", BW'(block_ready), BW'(1));
    check("mid_valid", BW'(mem_req_valid), BW'(0));
    check("mid_addr", BW'(mem_req_addr), BW'(0));
    check("mid_base", BW'(fill_base), BW'(0));
    check("mid_data", fill_data, BW'(0));
    check("mid_nb", BW'(new_block), BW'(0));
    repeat (4) tick();
    check("mid_no_pulse", BW'(nb_cnt - nb0), BW'(0));
    run_fill("post_rst", 16'h0040, 16'hF000, 18);

    // Spurious responses in IDLE and right after the last response.
    nb0 = nb_cnt;
    inj_req++;
    repeat (3) tick();
    check("spur_idle_data", fill_data, last_blk);
    check("spur_idle_nb", BW'(nb_cnt - nb0), BW'(0));
    spur_tail = 1'b1;
    run_fill("spur_tail", 16'h0707, 16'h1200, 18);
    spur_tail = 1'b0;
    repeat (2) tick();
    check("spur_tail_data", fill_data, last_blk);
    check("spur_tail_nb", BW'(nb_cnt - nb0), BW'(1));

    lat = 0;
    run_fill("zero_lat", 16'h0900, 16'h3300, 17);
    lat = 1;

    run_fill("wrap", 16'hFFFF, 16'h4400, 18);

    repeat (3) tick();
    check("blocks_left", BW'(exp_blk_q.size()), BW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
